// File: rtl/serial_rx_ctrl.sv
// Bit-serial receive controller: start/8 data/odd parity/stop framing
// into a show-ahead FIFO drained through a valid/ready port.
module serial_rx_ctrl #(
    parameter int DEPTH     = 4,
    parameter int PARITY_EN = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [7:0]                 rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       frame_err,
    output logic                       parity_err,
    output logic                       overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAR,
        STOP,
        RESYNC
    } state_t;

    state_t        state, state_n;
    logic [2:0]    cnt;
    logic [7:0]    shreg;
    logic          par_bit;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;

    logic par_ok, stop_good, stop_bad_par, stop_frame;
    logic push_req, push, pop;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (!in) state_n = DATA;
            DATA:    if (cnt == 3'd7) state_n = (PARITY_EN != 0) ? PAR : STOP;
            PAR:     state_n = STOP;
            STOP:    state_n = in ? IDLE : RESYNC;
            RESYNC:  if (in) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Odd parity: data bits plus parity bit must XOR to one
    assign par_ok       = (PARITY_EN == 0) || ((^shreg) ^ par_bit);
    assign stop_good    = (state == STOP) && in && par_ok;
    assign stop_bad_par = (state == STOP) && in && !par_ok;
    assign stop_frame   = (state == STOP) && !in;

    assign rd_valid = (level != '0);
    assign rd_data  = mem[rptr];
    assign pop      = rd_valid && rd_ready;
    assign push_req = stop_good;
    assign push     = push_req && ((level < LW'(DEPTH)) || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: cnt <= '0;
                DATA: begin
                    shreg <= {in, shreg[7:1]};
                    cnt   <= cnt + 3'd1;
                end
                PAR:     par_bit <= in;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= stop_frame;
            parity_err <= stop_bad_par;
            overrun    <= push_req && !push;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= shreg;
                wptr      <= wptr + AW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            if (push && !pop)      level <= level + LW'(1);
            else if (pop && !push) level <= level - LW'(1);
        end
    end
endmodule
